pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameter DEPTH, 4, pixel FIFO entries (power of 2, >=2).
REQ-002 Parameter XWIDTH, 320, frame width in pixels.
REQ-003 Parameter YWIDTH, 240, frame height in pixels.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 x  input  9  pixel column from render stage.
REQ-007 y  input  8  pixel row from render stage.
REQ-008 enable  input  1  pixel-valid strobe from render stage, one pixel per cycle high.
REQ-009 color  input  8  pixel value, sampled with x/y.
REQ-010 mem_ack  input  1  frame-memory write accept, single-cycle pulse.
REQ-011 mem_addr  output  17  linear write address.
REQ-012 mem_wdata  output  8  write data.
REQ-013 mem_wen  output  1  write request, registered.
REQ-014 full  output  1  FIFO holds DEPTH entries.
REQ-015 busy  output  1  FIFO non-empty or write outstanding.
REQ-016 overflow  output  1  sticky: pixel lost to full FIFO.
REQ-017 oob  output  1  sticky: pixel outside frame discarded.
REQ-018 flag_clr  input  1  synchronous clear of overflow and oob.

Function
REQ-019 Push: at a rising edge with enable=1, x<XWIDTH, y<YWIDTH, full=0, the entry {addr, color} SHALL be written to the FIFO tail.
REQ-020 Address SHALL be y*XWIDTH+x, computed at push, 17-bit, no truncation (max 76799).
REQ-021 enable=1 with x>=XWIDTH or y>=YWIDTH: no push; oob set at that edge.
REQ-022 enable=1 in-frame with full=1 (registered count): no push, overflow set, even if a pop occurs the same edge.
REQ-023 Simultaneous push and pop when not full: both occur, count unchanged, order preserved.
REQ-024 full = (count==DEPTH); busy = (count!=0) | mem_wen; both combinational from registers.
REQ-025 FSM states IDLE, WRITE.
REQ-026 IDLE: count>0 at an edge -> load head into mem_addr/mem_wdata, pop, mem_wen=1, go WRITE.
REQ-027 WRITE: mem_addr, mem_wdata, mem_wen held stable until mem_ack=1.
REQ-028 WRITE with mem_ack=1 and count>0: load next head, pop, stay WRITE, mem_wen stays 1 (back-to-back, one write per cycle).
REQ-029 WRITE with mem_ack=1 and count=0: mem_wen=0, go IDLE; mem_addr/mem_wdata hold last value.
REQ-030 mem_ack in IDLE SHALL be ignored.
REQ-031 Latency: pixel pushed at edge k into empty FIFO with FSM in IDLE -> mem_wen=1 with its address after edge k+1.
REQ-032 Writes SHALL issue in push order; no entry dropped or duplicated once pushed.
REQ-033 flag_clr=1 clears overflow/oob at the edge; a set event on the same edge wins (flag stays 1).
REQ-034 Pointers wrap modulo DEPTH.

Reset
REQ-035 n_rst=0 SHALL immediately: count=0, pointers=0, state IDLE, mem_wen=0, mem_addr=0, mem_wdata=0, overflow=0, oob=0.
REQ-036 Reset mid-write SHALL abandon the outstanding write and discard FIFO contents; no write issues after release until a new push.
REQ-037 After release, first push accepted at the first rising edge with n_rst=1.

Verification
REQ-038 Single pixel: x=10,y=10,color=8'hFF, enable one cycle, mem_ack held 1 -> mem_wen one cycle, mem_addr=3210, mem_wdata=8'hFF, busy falls next edge.
REQ-039 Backpressure: push 6 pixels (x=0..5,y=0) consecutively, mem_ack=0 -> first enters WRITE, 4 buffered, full=1, 6th dropped, overflow=1; then mem_ack=1 -> addresses 0,1,2,3,4 back-to-back, address 5 never written.
REQ-040 Corners: (0,0)->0, (319,239)->76799, (319,0)->319, (0,239)->76480.
REQ-041 Out of frame: x=320,y=0 and x=0,y=240 -> no mem_wen, oob=1; flag_clr one cycle -> oob=0.
REQ-042 Streaming: 320-pixel horizontal line y=119, enable every cycle, mem_ack=1 every cycle -> 320 writes addresses 38080..38399 in order, full never 1, overflow=0.
REQ-043 Reset mid-operation: 3 entries queued, mem_wen=1, assert n_rst -> mem_wen=0 and busy=0 immediately; after release no write without new enable.

Source files
------------

// File: rtl/pixel_writer.sv
// pixel_writer: accepts render-stage pixels, converts (x,y) to a linear
// frame-memory address, buffers them in a small FIFO and drains them to
// frame memory through a registered write/ack handshake.
module pixel_writer #(
  parameter int DEPTH  = 4,
  parameter int XWIDTH = 320,
  parameter int YWIDTH = 240
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  logic        enable,
  input  logic [7:0]  color,
  input  logic        mem_ack,
  input  logic        flag_clr,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wen,
  output logic        full,
  output logic        busy,
  output logic        overflow,
  output logic        oob
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [9:0]  XLIM = 10'(XWIDTH);
  localparam logic [8:0]  YLIM = 9'(YWIDTH);
  localparam logic [16:0] XW17 = 17'(XWIDTH);

  typedef enum logic {IDLE, WRITE} state_e;

  // FIFO entry layout: {address[16:0], color[7:0]}
  logic [24:0] fifo_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             oob_q, oob_d;

  state_e           state_q, state_d;
  logic [16:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_wen_q, mem_wen_d;

  logic             in_frame;
  logic             push;
  logic             pop;
  logic [16:0]      push_addr;
  logic [24:0]      head;

  // Frame bounds check and linear address, both evaluated at push time.
  assign in_frame  = ({1'b0, x} < XLIM) && ({1'b0, y} < YLIM);
  assign push_addr = 17'(y) * XW17 + 17'(x);

  // Status flags are derived from registered state only.
  assign full = (count_q == DEPTH_C);
  assign busy = (count_q != '0) | mem_wen_q;

  // A full FIFO refuses pixels even when a pop happens on the same edge.
  assign push = enable & in_frame & ~full;
  assign head = fifo_mem[rd_ptr_q];

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign overflow  = overflow_q;
  assign oob       = oob_q;

  // FIFO storage: written at the tail, no reset needed on contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {push_addr, color};
    end
  end

  // Next-state for FSM and memory-side output registers; pops the head.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = mem_wen_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        // mem_ack is meaningless here; only queued pixels start a write
        if (count_q != '0) begin
          mem_addr_d  = head[24:8];
          mem_wdata_d = head[7:0];
          mem_wen_d   = 1'b1;
          pop         = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          if (count_q != '0) begin
            // back-to-back: next pixel goes out on the cycle after the ack
            mem_addr_d  = head[24:8];
            mem_wdata_d = head[7:0];
            mem_wen_d   = 1'b1;
            pop         = 1'b1;
          end else begin
            // address/data keep their last value once the queue drains
            mem_wen_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_wen_d = 1'b0;
      end
    endcase
  end

  // Next-state for FIFO pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // a new error event on the clearing edge keeps the flag set
    overflow_d = (overflow_q & ~flag_clr) | (enable & in_frame & full);
    oob_d      = (oob_q & ~flag_clr) | (enable & ~in_frame);
  end

  // FSM and write-port registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
    end
  end

  // FIFO control and flag registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      oob_q      <= oob_d;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Testbench for pixel_writer: directed scenarios plus a randomized run
// checked cycle by cycle against a queue-based transaction model.
`timescale 1ns/1ps
module tb_pixel_writer;

  localparam int DEPTH = 4;
  localparam int XW    = 320;
  localparam int YH    = 240;

  logic        clk;
  logic        n_rst;
  logic [8:0]  x;
  logic [7:0]  y;
  logic        enable;
  logic [7:0]  color;
  logic        mem_ack;
  logic        flag_clr;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        full;
  logic        busy;
  logic        overflow;
  logic        oob;

  int checks   = 0;
  int failures = 0;

  // model state: pending pixels, the write in flight and sticky flags
  int          mq_addr[$];
  int          mq_data[$];
  bit          m_wen;
  logic [16:0] m_addr;
  logic [7:0]  m_data;
  bit          m_ovf;
  bit          m_oob;

  // writes completed by the DUT (mem_wen and mem_ack seen at an edge)
  int          obs_addr[$];

  pixel_writer #(.DEPTH(DEPTH), .XWIDTH(XW), .YWIDTH(YH)) dut (
    .clk(clk), .n_rst(n_rst), .x(x), .y(y), .enable(enable), .color(color),
    .mem_ack(mem_ack), .flag_clr(flag_clr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen), .full(full), .busy(busy),
    .overflow(overflow), .oob(oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    mq_addr.delete();
    mq_data.delete();
    m_wen  = 0;
    m_addr = '0;
    m_data = '0;
    m_ovf  = 0;
    m_oob  = 0;
  endtask

  // Transaction-level view of one clock edge.
  task automatic model_edge(input bit en, input int xx, input int yy,
                            input int cc, input bit ack, input bit clr);
    bit inframe = (xx < XW) && (yy < YH);
    bit is_full = (mq_addr.size() == DEPTH);
    bit ov_ev   = en && inframe && is_full;
    bit oob_ev  = en && !inframe;
    if (!m_wen || ack) begin
      if (mq_addr.size() > 0) begin
        m_wen  = 1;
        m_addr = 17'(mq_addr.pop_front());
        m_data = 8'(mq_data.pop_front());
      end else begin
        m_wen = 0;
      end
    end
    if (en && inframe && !is_full) begin
      mq_addr.push_back(yy * XW + xx);
      mq_data.push_back(cc & 255);
    end
    m_ovf = (m_ovf && !clr) || ov_ev;
    m_oob = (m_oob && !clr) || oob_ev;
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic cycle(input bit en, input int xx, input int yy,
                       input int cc, input bit ack, input bit clr);
    enable   = en;
    x        = xx[8:0];
    y        = yy[7:0];
    color    = cc[7:0];
    mem_ack  = ack;
    flag_clr = clr;
    if (mem_wen && ack) begin
      obs_addr.push_back(int'(mem_addr));
      $display("write addr=%0d data=%02h", mem_addr, mem_wdata);
    end
    @(posedge clk);
    model_edge(en, xx, yy, cc, ack, clr);
    #1;
  endtask

  task automatic do_reset();
    n_rst    = 1'b0;
    enable   = 1'b0;
    x        = '0;
    y        = '0;
    color    = '0;
    mem_ack  = 1'b0;
    flag_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    obs_addr.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b exp=0", mem_wen); end
    checks++; if (mem_addr !== 17'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (mem_wdata !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", mem_wdata); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (oob !== 1'b0) begin failures++; $display("FAIL reset_oob got=%0b exp=0", oob); end
    // first edge after release accepts a pixel; write appears one edge later
    cycle(1, 5, 2, 8'h33, 0, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL release_push_busy got=%0b exp=1", busy); end
    checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL latency_early_wen got=%0b exp=0", mem_wen); end
    cycle(0, 0, 0, 0, 0, 0);
    checks++; if (mem_wen !== 1'b1) begin failures++; $display("FAIL latency_wen got=%0b exp=1", mem_wen); end
    checks++; if (mem_addr !== 17'd645) begin failures++; $display("FAIL latency_addr got=%0d exp=645", mem_addr); end
    checks++; if (mem_wdata !== 8'h33) begin failures++; $display("FAIL latency_wdata got=%0h exp=33", mem_wdata); end
    $display("test_reset done");
  endtask

  task automatic test_single_pixel();
    do_reset();
    cycle(1, 10, 10, 8'hFF, 1, 0);
    checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL single_wen0 got=%0b exp=0", mem_wen); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (mem_wen !== 1'b1) begin failures++; $display("FAIL single_wen1 got=%0b exp=1", mem_wen); end
    checks++; if (mem_addr !== 17'd3210) begin failures++; $display("FAIL single_addr got=%0d exp=3210", mem_addr); end
    checks++; if (mem_wdata !== 8'hFF) begin failures++; $display("FAIL single_wdata got=%0h exp=ff", mem_wdata); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy1 got=%0b exp=1", busy); end
    cycle(0, 0, 0, 0, 1, 0);
    checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL single_wen_end got=%0b exp=0", mem_wen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%0b exp=0", busy); end
    checks++; if (mem_addr !== 17'd3210) begin failures++; $display("FAIL single_addr_hold got=%0d exp=3210", mem_addr); end
    repeat (3) cycle(0, 0, 0, 0, 1, 0);
    checks++; if (obs_addr.size() != 1) begin failures++; $display("FAIL single_write_count got=%0d exp=1", obs_addr.size()); end
    $display("test_single_pixel done");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, i, 0, 8'h40 + i, 0, 0);
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL bp_full got=%0b exp=1", full); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%0b exp=1", overflow); end
    checks++; if (mem_wen !== 1'b1) begin failures++; $display("FAIL bp_wen got=%0b exp=1", mem_wen); end
    checks++; if (mem_addr !== 17'd0) begin failures++; $display("FAIL bp_addr_held got=%0d exp=0", mem_addr); end
    repeat (8) cycle(0, 0, 0, 0, 1, 0);
    checks++; if (obs_addr.size() != 5) begin failures++; $display("FAIL bp_write_count got=%0d exp=5", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 5; i++) begin
      checks++; if (obs_addr[i] != i) begin failures++; $display("FAIL bp_order[%0d] got=%0d exp=%0d", i, obs_addr[i], i); end
    end
    checks++; if (full !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_drained full=%0b busy=%0b exp=0,0", full, busy); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow_sticky got=%0b exp=1", overflow); end
    $display("test_backpressure done");
  endtask

  task automatic test_corners();
    int exp_a[4];
    int cx[4];
    int cy[4];
    exp_a = '{0, 76799, 319, 76480};
    cx    = '{0, 319, 319, 0};
    cy    = '{0, 239, 0, 239};
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, cx[i], cy[i], i + 1, 1, 0);
    repeat (6) cycle(0, 0, 0, 0, 1, 0);
    checks++; if (obs_addr.size() != 4) begin failures++; $display("FAIL corner_count got=%0d exp=4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++; if (obs_addr[i] != exp_a[i]) begin failures++; $display("FAIL corner[%0d] got=%0d exp=%0d", i, obs_addr[i], exp_a[i]); end
    end
    checks++; if (oob !== 1'b0) begin failures++; $display("FAIL corner_oob got=%0b exp=0", oob); end
    $display("test_corners done");
  endtask

  task automatic test_oob();
    do_reset();
    cycle(1, 320, 0, 8'h11, 1, 0);
    checks++; if (oob !== 1'b1) begin failures++; $display("FAIL oob_x got=%0b exp=1", oob); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL oob_busy got=%0b exp=0", busy); end
    cycle(1, 0, 240, 8'h22, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL oob_no_write[%0d] got=%0b exp=0", i, mem_wen); end
    end
    checks++; if (oob !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL oob_flags oob=%0b ovf=%0b exp=1,0", oob, overflow); end
    // clear and new event on the same edge: set wins
    cycle(1, 400, 5, 0, 1, 1);
    checks++; if (oob !== 1'b1) begin failures++; $display("FAIL oob_set_wins got=%0b exp=1", oob); end
    cycle(0, 0, 0, 0, 1, 1);
    checks++; if (oob !== 1'b0) begin failures++; $display("FAIL oob_clear got=%0b exp=0", oob); end
    checks++; if (obs_addr.size() != 0) begin failures++; $display("FAIL oob_writes got=%0d exp=0", obs_addr.size()); end
    $display("test_oob done");
  endtask

  task automatic test_back_to_back();
    bit full_seen = 0;
    do_reset();
    for (int i = 0; i < 320; i++) begin
      cycle(1, i, 119, i & 255, 1, 0);
      if (full === 1'b1) full_seen = 1;
    end
    repeat (4) cycle(0, 0, 0, 0, 1, 0);
    checks++; if (full_seen) begin failures++; $display("FAIL stream_full got=1 exp=0"); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL stream_overflow got=%0b exp=0", overflow); end
    checks++; if (obs_addr.size() != 320) begin failures++; $display("FAIL stream_count got=%0d exp=320", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 320; i++) begin
      checks++; if (obs_addr[i] != 38080 + i) begin failures++; $display("FAIL stream_addr[%0d] got=%0d exp=%0d", i, obs_addr[i], 38080 + i); end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 20 + i, 3, i, 0, 0);
    checks++; if (mem_wen !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL midrst_pre wen=%0b busy=%0b exp=1,1", mem_wen, busy); end
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL midrst_wen got=%0b exp=0", mem_wen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, i[0], 0);
      checks++; if (mem_wen !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_after[%0d] wen=%0b busy=%0b exp=0,0", i, mem_wen, busy); end
    end
    $display("test_reset_mid_write done");
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 700; i++) begin
      bit en  = ($urandom_range(0, 99) < 70);
      int xx  = ($urandom_range(0, 19) == 0) ? $urandom_range(320, 335) : $urandom_range(0, 319);
      int yy  = ($urandom_range(0, 19) == 0) ? $urandom_range(240, 250) : $urandom_range(0, 239);
      int cc  = $urandom_range(0, 255);
      bit ack = ($urandom_range(0, 99) < 45);
      bit clr = ($urandom_range(0, 29) == 0);
      cycle(en, xx, yy, cc, ack, clr);
      checks++;
      if (mem_wen !== m_wen || mem_addr !== m_addr || mem_wdata !== m_data ||
          full !== (mq_addr.size() == DEPTH) || busy !== (mq_addr.size() != 0 || m_wen) ||
          overflow !== m_ovf || oob !== m_oob) begin
        failures++;
        bad++;
        if (bad <= 20)
          $display("FAIL random[%0d] got wen=%0b addr=%0d data=%0h full=%0b busy=%0b ovf=%0b oob=%0b exp wen=%0b addr=%0d data=%0h full=%0b busy=%0b ovf=%0b oob=%0b",
                   i, mem_wen, mem_addr, mem_wdata, full, busy, overflow, oob,
                   m_wen, m_addr, m_data, mq_addr.size() == DEPTH, (mq_addr.size() != 0 || m_wen), m_ovf, m_oob);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_backpressure();
    test_corners();
    test_oob();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
